// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: architectural HI/LO, multi-cycle mult/div, single-cycle mthi/mtlo.
// Optional madd/maddu accumulate is compiled in when MDU_MADD_EN is defined.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdSel,
  output logic [31:0] Out,
  output logic        Busy
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  typedef enum logic [1:0] {
    PEND_NONE    = 2'd0,
    PEND_COMMIT  = 2'd1,
    PEND_DISCARD = 2'd2
  } pend_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } md_op_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  pend_t       pend_q, pend_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

  // Low 64 bits of the product of sign-extended operands equal the signed 64-bit product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide through magnitudes so INT_MIN / -1 and sign rules are explicit.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, div_s_den, div_u_den;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign a_neg     = A[31];
  assign b_neg     = B[31];
  assign b_zero    = (B == 32'd0);
  assign a_mag     = a_neg ? (~A + 32'd1) : A;
  assign b_mag     = b_neg ? (~B + 32'd1) : B;
  assign div_s_den = b_zero ? 32'd1 : b_mag;
  assign div_u_den = b_zero ? 32'd1 : B;
  assign q_mag     = a_mag / div_s_den;
  assign r_mag     = a_mag % div_s_den;
  assign q_s       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s       = a_neg ? (~r_mag + 32'd1) : r_mag;
  assign q_u       = A / div_u_den;
  assign r_u       = A % div_u_den;

`ifdef MDU_MADD_EN
  logic [63:0] acc_s, acc_u;
  assign acc_s = {hi_q, lo_q} + prod_s;
  assign acc_u = {hi_q, lo_q} + prod_u;
`endif

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT: begin
              {tmp_hi_d, tmp_lo_d} = prod_s;
              cnt_d   = MULT_CNT;
              pend_d  = PEND_COMMIT;
              state_d = S_BUSY;
            end
            OP_MULTU: begin
              {tmp_hi_d, tmp_lo_d} = prod_u;
              cnt_d   = MULT_CNT;
              pend_d  = PEND_COMMIT;
              state_d = S_BUSY;
            end
            OP_DIV: begin
              tmp_hi_d = r_s;
              tmp_lo_d = q_s;
              cnt_d    = DIV_CNT;
              pend_d   = b_zero ? PEND_DISCARD : PEND_COMMIT;
              state_d  = S_BUSY;
            end
            OP_DIVU: begin
              tmp_hi_d = r_u;
              tmp_lo_d = q_u;
              cnt_d    = DIV_CNT;
              pend_d   = b_zero ? PEND_DISCARD : PEND_COMMIT;
              state_d  = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {tmp_hi_d, tmp_lo_d} = acc_s;
              cnt_d   = MULT_CNT;
              pend_d  = PEND_COMMIT;
              state_d = S_BUSY;
            end
            OP_MADDU: begin
              {tmp_hi_d, tmp_lo_d} = acc_u;
              cnt_d   = MULT_CNT;
              pend_d  = PEND_COMMIT;
              state_d = S_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // Start is ignored here; the hazard unit keeps HI/LO users out of E while busy.
        if (cnt_q <= 4'd1) begin
          if (pend_q == PEND_COMMIT) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
          cnt_d   = 4'd0;
          pend_d  = PEND_NONE;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pend_q   <= PEND_NONE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
    end
  end

  assign Busy = (state_q == S_BUSY);
  assign Out  = RdSel ? lo_q : hi_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected HI/LO per completion or probe,
// a monitor compares at each Busy fall and on each requested probe.
module tb_e_mdu;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        RdSel = 1'b0;
  logic [31:0] Out;
  logic        Busy;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .RdSel(RdSel), .Out(Out), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    int          busy_len;
    logic [31:0] hi;
    logic [31:0] lo;
  } op_exp_t;

  typedef struct {
    string       name;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } probe_exp_t;

  op_exp_t    op_q[$];
  probe_exp_t probe_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: owns RdSel, reads HI then LO away from the rising edge.
  initial begin
    bit          prev_busy;
    bit          busy_now;
    int          run;
    logic [31:0] hi_v, lo_v;
    op_exp_t     e;
    probe_exp_t  p;
    prev_busy = 0;
    run = 0;
    forever begin
      @(negedge Clk);
      busy_now = (Busy === 1'b1);
      RdSel = 1'b0;
      #1 hi_v = Out;
      RdSel = 1'b1;
      #1 lo_v = Out;
      if (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        check({p.name, "_busy"}, 32'(busy_now), 32'(p.busy));
        check({p.name, "_hi"}, hi_v, p.hi);
        check({p.name, "_lo"}, lo_v, p.lo);
      end
      if (busy_now) run++;
      else if (prev_busy) begin
        if (op_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_completion: busy ran %0d cycles with no operation pending", run);
        end else begin
          e = op_q.pop_front();
          check({e.name, "_busy_len"}, 32'(run), 32'(e.busy_len));
          check({e.name, "_hi"}, hi_v, e.hi);
          check({e.name, "_lo"}, lo_v, e.lo);
        end
        run = 0;
      end
      prev_busy = busy_now;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (Busy === 1'b1) begin
      n_checks++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic expect_op(input string name, input int len, input logic [31:0] hi, input logic [31:0] lo);
    op_exp_t e;
    e.name = name; e.busy_len = len; e.hi = hi; e.lo = lo;
    op_q.push_back(e);
  endtask

  task automatic probe(input string name, input logic busy, input logic [31:0] hi, input logic [31:0] lo);
    probe_exp_t p;
    p.name = name; p.busy = busy; p.hi = hi; p.lo = lo;
    probe_q.push_back(p);
    step();
  endtask

  initial begin
    int n;
    step();
    step();
    Reset = 1'b0;
    probe("reset", 1'b0, 32'h0, 32'h0);

    expect_op("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    start_op(3'b000, 32'hFFFF_FFFF, 32'd2);
    step();
    probe("mult_midbusy", 1'b1, 32'h0, 32'h0);
    wait_idle("mult");

    // Issued in the first idle cycle: no dead cycle allowed.
    expect_op("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
    start_op(3'b001, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");

    expect_op("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");

    expect_op("divu", 10, 32'd1, 32'd3);
    start_op(3'b011, 32'd7, 32'd2);
    wait_idle("divu");

    expect_op("div_ovf", 10, 32'h0, 32'h8000_0000);
    start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    start_op(3'b100, 32'h1234_5678, 32'd0);
    probe("mthi", 1'b0, 32'h1234_5678, 32'h8000_0000);
    start_op(3'b101, 32'h0, 32'd0);
    probe("mtlo", 1'b0, 32'h1234_5678, 32'h0);

    expect_op("div_by_zero", 10, 32'h1234_5678, 32'h0);
    start_op(3'b010, 32'd5, 32'd0);
    wait_idle("div_by_zero");

    expect_op("mult_ign_mtlo", 5, 32'h0, 32'd12);
    start_op(3'b000, 32'd3, 32'd4);
    step();
    start_op(3'b101, 32'h0000_DEAD, 32'd0);
    wait_idle("mult_ign_mtlo");
    probe("after_ign_mtlo", 1'b0, 32'h0, 32'd12);

    start_op(3'b100, 32'h0, 32'd0);
    start_op(3'b101, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
    expect_op("maddu", 5, 32'd1, 32'h0);
    start_op(3'b111, 32'd1, 32'd1);
    wait_idle("maddu");
    expect_op("madd", 5, 32'h0, 32'hFFFF_FFFF);
    start_op(3'b110, 32'hFFFF_FFFF, 32'd1);
    wait_idle("madd");
`else
    start_op(3'b111, 32'd1, 32'd1);
    probe("maddu_off", 1'b0, 32'h0, 32'hFFFF_FFFF);
    start_op(3'b110, 32'hFFFF_FFFF, 32'd1);
    probe("madd_off", 1'b0, 32'h0, 32'hFFFF_FFFF);
`endif

    // Reset lands at the end of busy cycle 4.
    expect_op("div_reset", 4, 32'h0, 32'h0);
    start_op(3'b010, 32'd100, 32'd7);
    step();
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 15; i++) step();
    probe("post_reset_quiet", 1'b0, 32'h0, 32'h0);

    // Start coinciding with Reset must be dropped.
    Reset = 1'b1;
    start_op(3'b100, 32'h0000_0055, 32'd0);
    Reset = 1'b0;
    probe("start_during_reset", 1'b0, 32'h0, 32'h0);

    n = 0;
    while ((op_q.size() > 0 || probe_q.size() > 0) && n < 50) begin
      step();
      n++;
    end
    if (op_q.size() > 0 || probe_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d ops and %0d probes still pending, required none",
               op_q.size(), probe_q.size());
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
